riscv_fetch: RTL
================

Name: riscv_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the core's decode/execute stage. It replaces the in-core `cur <= mem[pc]` step.
- Drives a synchronous, word-organised instruction memory and keeps byte-addressed PCs. It buffers fetched words with their PCs in a small FIFO.
- Hands instructions downstream over a valid/ready handshake.
- Accepts redirects from the execute stage for JAL, JALR and taken branches. On a redirect it flushes all wrong-path state.

Parameters:
- XLEN, 32, data and PC width.
- IMEM_AW, 10, instruction memory word-address width (1024 words, 4096 bytes).
- FIFO_DEPTH, 2, entries in the instruction buffer. Must be ≥2 and a power of 2.
- RESET_PC, 32'h0, byte address fetched first after reset.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  IMEM_AW  word address, equal to fetch_pc[IMEM_AW+1:2].
- imem_rdata  in  XLEN  read data. Valid in the cycle after imem_en was high (1-cycle synchronous read).
- redirect_valid  in  1  execute stage requests a PC change.
- redirect_pc  in  XLEN  new byte PC.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  downstream accepts the instruction this cycle.
- inst  out  XLEN  instruction word.
- inst_pc  out  XLEN  byte PC of inst.
- fetch_pc  out  XLEN  PC of the next read to issue (debug/gpio).

Behaviour:
- Reset (async, on rst_n low):
  - fetch_pc = RESET_PC.
  - FIFO empty; pending = 0.
  - imem_en = 0, inst_valid = 0, inst = 0, inst_pc = 0.
  - Any response in flight is discarded.
- PCs are byte addresses. Sequential fetch adds 4 to fetch_pc.
  - fetch_pc wraps modulo 2^32.
  - imem_addr truncates, so it wraps modulo 2^IMEM_AW words.
- pending = 1 iff a read was issued last cycle.
- pop = inst_valid & inst_ready.
- Issue rule, in a cycle with no redirect: imem_en = 1 iff count + pending − pop < FIFO_DEPTH.
  - At most one read per cycle.
  - fetch_pc += 4 on each issue.
- Response: when pending is set and the read was not killed, {imem_rdata, issued_pc} is pushed into the FIFO at the clock edge ending the response cycle.
- Latency: a read issued in cycle N gives inst_valid in cycle N+2 if the FIFO was empty. There is no bypass.
- Throughput: sustained 1 instruction/cycle with inst_ready held high and FIFO_DEPTH ≥ 2.
- Handshake:
  - inst, inst_pc and inst_valid are driven from the FIFO head.
  - While inst_valid & !inst_ready, they stay stable.
  - inst_valid never drops without a pop, except on a redirect.
- Redirect (redirect_valid = 1) has priority over everything:
  - imem_en = 0 in that cycle.
  - FIFO cleared at the edge.
  - A response arriving in the cycle after the redirect is killed. Implement with an epoch bit or a kill flag on pending.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}; the low two bits are ignored.
  - The first read at the new PC issues in the next cycle, so inst_valid returns at the earliest 3 cycles after the redirect cycle.
  - A pop in the redirect cycle still counts as accepted.
- Simultaneous push and pop on a full FIFO is legal. The issue rule guarantees no overflow.
  - Push into a full FIFO or pop from an empty one is a design error; flag it with an assertion in simulation.
- redirect_valid held high for multiple cycles: each cycle re-flushes, and the last redirect_pc wins.

Decomposition:
- Shared definitions go in config.vh: XLEN/WORD width, RESET_PC and IMEM_AW defaults. Nothing new goes in instructions.vh.
- One sub-module: riscv_fetch_fifo.
  - Synchronous FIFO of {pc, inst}, width 2*XLEN.
  - Ports: push, pop, flush, count, head.
  - Count and pointer wrap modulo FIFO_DEPTH.
- The parent keeps fetch_pc, pending/kill and the issue logic.

Test Plan:
- Reset: mem[0..3] = 0x11,0x22,0x33,0x44 and inst_ready = 1 → inst_valid first high 2 cycles after the first imem_en. Then (inst, inst_pc) = (0x11,0),(0x22,4),(0x33,8),(0x44,0xC) on consecutive cycles.
- Backpressure: drop inst_ready for 5 cycles while inst_pc = 4 → inst = 0x22 is held stable. No more than FIFO_DEPTH words are buffered, imem_en stays low once full, and resuming ready gives 4, 8, 0xC with no loss or duplicate.
- Redirect while the FIFO is full with a read in flight: redirect_pc = 0x80, mem[0x20] = 0xAA → no old-stream word appears. The next valid output is (0xAA, 0x80), 3 cycles after the redirect.
- Misaligned redirect: redirect_pc = 0x83 → imem_addr = 0x20 and inst_pc = 0x80.
- Wrap: redirect to 0xFFC with IMEM_AW = 10 → imem_addr 1023 then 0, with inst_pc 0xFFC then 0x1000.
- Async reset: pull rst_n low mid-stream between clock edges → inst_valid and imem_en go 0 immediately. After release, fetch restarts at RESET_PC and no stale word is delivered.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared defaults for the instruction fetch stage.
// Widths, reset PC and buffer geometry live here.
package riscv_fetch_pkg;

  localparam int XLEN_D = 32;
  localparam int IMEM_AW_D = 10;
  localparam int FIFO_DEPTH_D = 2;
  localparam logic [XLEN_D-1:0] RESET_PC_D = '0;

  localparam int ILEN_B = 4;

  function automatic logic [XLEN_D-1:0] align_pc(
    input logic [XLEN_D-1:0] pc
  );
    return {pc[XLEN_D-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} entries.
// Flush empties it in one edge; pointers wrap modulo DEPTH.
module riscv_fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [AW:0]   count,
  output logic [W-1:0]  head
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;

  assign head = mem[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && !pop && count == FULL));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Fetch stage: issues word reads, buffers {pc, inst}, and
// hands them downstream; redirects flush wrong-path state.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int IMEM_AW = IMEM_AW_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_D
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [XLEN-1:0]    inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic [XLEN-1:0]    fetch_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            pending;
  logic [XLEN-1:0] pend_pc;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [CW:0]     lim;
  logic [2*XLEN-1:0] head;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;

  // A response landing in a redirect cycle is wrong-path: drop it.
  assign push = pending & ~redirect_valid;

  assign occ   = {1'b0, count} + (CW+1)'(pending);
  assign lim   = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign issue = rst_n & ~redirect_valid & (occ < lim);

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  assign inst    = head[XLEN-1:0];
  assign inst_pc = head[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pending  <= 1'b0;
      pend_pc  <= '0;
    end else begin
      pending <= issue;
      if (issue) pend_pc <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (issue)
        fetch_pc <= fetch_pc + XLEN'(ILEN_B);
    end
  end

  riscv_fetch_fifo #(
    .W     (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pend_pc, imem_rdata}),
    .count (count),
    .head  (head)
  );

endmodule
